// File: rtl/msg_pkg.sv
// Shared constants, field positions and FSM state type for the message endpoint.
// Request and reply layouts are defined here once and sliced everywhere else.
package msg_pkg;

    localparam int W_MSG  = 64;
    localparam int W_DATA = 32;
    localparam int W_OPC  = 4;
    localparam int W_SRC  = 4;
    localparam int W_NODE = 4;
    localparam int W_ADDR = 3;
    localparam int N_REGS = 8;
    localparam int W_CNT  = 8;

    // Request fields
    localparam int OPC_LSB  = 60;
    localparam int SRC_LSB  = 56;
    localparam int ADDR_LSB = 53;
    localparam int RSVD_LSB = 32;
    localparam int W_RSVD   = 21;
    localparam int DATA_LSB = 0;

    // Reply fields; code and result share the request's opcode/data positions
    localparam int RPL_NODE_LSB = 56;
    localparam int RPL_ADDR_LSB = 53;
    localparam int RPL_SRC_LSB  = 49;

    localparam logic [W_OPC-1:0] OP_NOP   = 4'h0;
    localparam logic [W_OPC-1:0] OP_WRITE = 4'h1;
    localparam logic [W_OPC-1:0] OP_READ  = 4'h2;
    localparam logic [W_OPC-1:0] OP_ADD   = 4'h3;

    localparam logic [W_OPC-1:0] RC_RESP = 4'h8;
    localparam logic [W_OPC-1:0] RC_ERR  = 4'hF;

    localparam logic [W_CNT-1:0] ERR_CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        EXEC,
        SEND
    } state_t;

    function automatic logic [W_MSG-1:0] build_reply(
        input logic [W_OPC-1:0]  code,
        input logic [W_NODE-1:0] node,
        input logic [W_ADDR-1:0] addr,
        input logic [W_SRC-1:0]  src,
        input logic [W_DATA-1:0] result
    );
        logic [W_MSG-1:0] r;
        r = '0;
        r[OPC_LSB      +: W_OPC]  = code;
        r[RPL_NODE_LSB +: W_NODE] = node;
        r[RPL_ADDR_LSB +: W_ADDR] = addr;
        r[RPL_SRC_LSB  +: W_SRC]  = src;
        r[DATA_LSB     +: W_DATA] = result;
        return r;
    endfunction

endpackage

// File: rtl/msg_endpoint_if.sv
// Inbound/outbound FIFO handshake bundle; master is the FIFO side, slave the endpoint.
interface msg_endpoint_if;

    logic                      in_msg_rdy;
    logic [msg_pkg::W_MSG-1:0] in_msg;
    logic                      in_msg_ack;
    logic                      out_msg_rdy;
    logic [msg_pkg::W_MSG-1:0] out_msg;
    logic                      out_msg_ack;

    modport master (
        output in_msg_rdy, in_msg, out_msg_ack,
        input  in_msg_ack, out_msg_rdy, out_msg
    );

    modport slave (
        input  in_msg_rdy, in_msg, out_msg_ack,
        output in_msg_ack, out_msg_rdy, out_msg
    );

endinterface

// File: rtl/msg_regfile.sv
// 8x32 register file: combinational read port, synchronous write port.
module msg_regfile
    import msg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [W_ADDR-1:0] rd_addr_i,
    output logic [W_DATA-1:0] rd_data_o,
    input  logic              we_i,
    input  logic [W_ADDR-1:0] wr_addr_i,
    input  logic [W_DATA-1:0] wr_data_i
);

    logic [W_DATA-1:0] mem_q [N_REGS];

    assign rd_data_o = mem_q[rd_addr_i];

    // NOTE: eight words are small enough to live in flops, so every entry
    // is cleared on reset; a RAM-backed file could not be reset like this.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/msg_endpoint.sv
// Message endpoint: pops one request, executes it on the register file and
// presents the reply until the outbound FIFO acknowledges it.
module msg_endpoint
    import msg_pkg::*;
#(
    parameter logic [W_NODE-1:0] NODE_ID = 4'h0
) (
    input  logic             clk,
    input  logic             rst,
    msg_endpoint_if.slave    msg,
    output logic             busy,
    output logic [W_CNT-1:0] err_cnt
);

    state_t            state_q;
    logic [W_OPC-1:0]  opc_q;
    logic [W_SRC-1:0]  src_q;
    logic [W_ADDR-1:0] addr_q;
    logic [W_DATA-1:0] data_q;
    logic [W_MSG-1:0]  out_msg_q;
    logic [W_CNT-1:0]  err_cnt_q;

    logic [W_DATA-1:0] rd_data;
    logic [W_DATA-1:0] sum_d;
    logic [W_DATA-1:0] result_d;
    logic [W_DATA-1:0] wr_data_d;
    logic [W_OPC-1:0]  code_d;
    logic              we_d;
    logic              reply_d;
    logic              err_d;

    // The reserved request bits carry nothing the endpoint needs.
    logic unused_rsvd;
    assign unused_rsvd = ^msg.in_msg[RSVD_LSB +: W_RSVD];

    msg_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_i (addr_q),
        .rd_data_o (rd_data),
        .we_i      (we_d && (state_q == EXEC)),
        .wr_addr_i (addr_q),
        .wr_data_i (wr_data_d)
    );

    assign sum_d = rd_data + data_q;

    // NOTE: every output gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        we_d      = 1'b0;
        wr_data_d = data_q;
        result_d  = '0;
        code_d    = RC_RESP;
        reply_d   = 1'b1;
        err_d     = 1'b0;
        case (opc_q)
            OP_NOP:   reply_d = 1'b0;
            OP_WRITE: begin
                we_d     = 1'b1;
                result_d = data_q;
            end
            OP_READ:  result_d = rd_data;
            OP_ADD: begin
                we_d      = 1'b1;
                wr_data_d = sum_d;
                result_d  = sum_d;
            end
            default: begin
                code_d   = RC_ERR;
                result_d = {{(W_DATA - W_OPC){1'b0}}, opc_q};
                err_d    = 1'b1;
            end
        endcase
    end

    // NOTE: all state here updates with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            opc_q     <= '0;
            src_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            out_msg_q <= '0;
            err_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (msg.in_msg_rdy) begin
                    opc_q   <= msg.in_msg[OPC_LSB  +: W_OPC];
                    src_q   <= msg.in_msg[SRC_LSB  +: W_SRC];
                    addr_q  <= msg.in_msg[ADDR_LSB +: W_ADDR];
                    data_q  <= msg.in_msg[DATA_LSB +: W_DATA];
                    state_q <= POP;
                end
                POP:  state_q <= EXEC;
                EXEC: begin
                    if (reply_d) begin
                        out_msg_q <= build_reply(code_d, NODE_ID, addr_q, src_q, result_d);
                        state_q   <= SEND;
                    end else begin
                        state_q <= IDLE;
                    end
                    if (err_d && (err_cnt_q != ERR_CNT_MAX)) begin
                        err_cnt_q <= err_cnt_q + 8'd1;
                    end
                end
                SEND: if (msg.out_msg_ack) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign msg.in_msg_ack  = (state_q == POP);
    assign msg.out_msg_rdy = (state_q == SEND);
    assign msg.out_msg     = out_msg_q;
    assign busy            = (state_q != IDLE);
    assign err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_msg_endpoint.sv
// Scoreboard bench for msg_endpoint: a driver issues requests and pushes the
// reference model's replies; a monitor pops and compares each presented reply.
module tb_msg_endpoint;

    localparam logic [3:0] NODE = 4'h5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [7:0] err_cnt;

    msg_endpoint_if bus ();

    msg_endpoint #(.NODE_ID(NODE)) dut (
        .clk     (clk),
        .rst     (rst),
        .msg     (bus),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [63:0] exp_q [$];

    // Reference state: the eight registers and the saturating error count
    logic [31:0] regs_m [8];
    int          err_m;

    logic        mon_prev_rdy = 1'b0;
    logic [63:0] mon_held     = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 8; i++) regs_m[i] = '0;
        err_m = 0;
    endtask

    function automatic logic [63:0] mk(input logic [3:0] op, input logic [3:0] src,
                                       input logic [2:0] a, input logic [31:0] d);
        logic [20:0] junk;
        junk = 21'($urandom);
        return {op, src, a, junk, d};
    endfunction

    // Behavioural meaning of one request; reply is code|node|addr|src|17 zeros|result
    task automatic model(input logic [63:0] m, output bit has, output logic [63:0] rep);
        logic [3:0]  op;
        logic [3:0]  src;
        logic [2:0]  a;
        logic [31:0] d;
        logic [31:0] res;
        logic [3:0]  code;
        op   = m[63:60];
        src  = m[59:56];
        a    = m[55:53];
        d    = m[31:0];
        has  = 1'b1;
        code = 4'h8;
        res  = '0;
        if (op == 4'h0) begin
            has = 1'b0;
        end else if (op == 4'h1) begin
            regs_m[a] = d;
            res = d;
        end else if (op == 4'h2) begin
            res = regs_m[a];
        end else if (op == 4'h3) begin
            regs_m[a] = regs_m[a] + d;
            res = regs_m[a];
        end else begin
            code = 4'hF;
            res  = 32'(op);
            if (err_m < 255) err_m++;
        end
        rep = {code, NODE, a, src, 17'h0, res};
    endtask

    // Drive one request through the full handshake; optionally reset while the reply is held.
    task automatic do_req(input logic [63:0] m, input int ack_delay, input bit rst_in_send);
        bit          has;
        logic [63:0] rep;
        int          n;
        model(m, has, rep);
        if (has) exp_q.push_back(rep);
        bus.in_msg     = m;
        bus.in_msg_rdy = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.in_msg_ack && n < 20);
        check("ack_latency", n, 1);
        // Endpoint is busy now: rdy noise and a foreign head must be ignored
        bus.in_msg      = mk(4'h1, 4'h0, 3'($urandom), $urandom);
        bus.in_msg_rdy  = 1'($urandom);
        if (has) begin
            do begin @(posedge clk); #1; n++; end while (!bus.out_msg_rdy && n < 40);
            check("rdy_latency", n, 3);
            repeat (ack_delay) begin @(posedge clk); #1; end
            if (rst_in_send) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                reset_model();
                check("rst_send_rdy", bus.out_msg_rdy, 0);
                check("rst_send_out", bus.out_msg, 64'h0);
            end else begin
                bus.out_msg_ack = 1'b1;
                @(posedge clk); #1;
                bus.out_msg_ack = 1'b0;
                check("rdy_drop", bus.out_msg_rdy, 0);
            end
        end else begin
            bus.out_msg_ack = 1'($urandom);
            repeat (2) begin @(posedge clk); #1; end
            bus.out_msg_ack = 1'b0;
        end
        bus.in_msg_rdy = 1'b0;
        check("busy_idle", busy, 0);
        check("err_cnt", err_cnt, 64'(err_m));
    endtask

    // Monitor: compares each newly presented reply and its stability/hold behaviour
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev_rdy = 1'b0;
                mon_held     = '0;
                exp_q.delete();
            end else if (bus.out_msg_rdy && !mon_prev_rdy) begin
                check("reply_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("reply", bus.out_msg, exp_q.pop_front());
                mon_held     = bus.out_msg;
                mon_prev_rdy = 1'b1;
            end else if (bus.out_msg_rdy) begin
                check("out_stable", bus.out_msg, mon_held);
                check("no_pop_in_send", bus.in_msg_ack, 0);
            end else begin
                check("out_hold", bus.out_msg, mon_held);
                mon_prev_rdy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int last;
        int cnt;
        int r;
        logic [3:0] op;
        bus.in_msg_rdy  = 1'b0;
        bus.in_msg      = '0;
        bus.out_msg_ack = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_out_rdy", bus.out_msg_rdy, 0);
        check("rst_in_ack", bus.in_msg_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_out_msg", bus.out_msg, 64'h0);

        // Directed: addr 3 lands in [55:53] and src 2 in [52:49]
        do_req(mk(4'h1, 4'h2, 3'd3, 32'hDEADBEEF), 0, 1'b0);
        do_req(mk(4'h2, 4'h1, 3'd3, 32'h0), 1, 1'b0);
        do_req(mk(4'h2, 4'h1, 3'd4, 32'h0), 0, 1'b0);
        do_req(mk(4'h1, 4'h3, 3'd1, 32'hFFFFFFFF), 0, 1'b0);
        do_req(mk(4'h3, 4'h3, 3'd1, 32'h2), 2, 1'b0);
        do_req(mk(4'h7, 4'h9, 3'd2, 32'h1234), 0, 1'b0);
        check("err_after_one", err_cnt, 1);
        do_req(mk(4'h1, 4'hE, 3'd6, 32'hCAFEF00D), 10, 1'b0);

        // Randomized mix
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       op = 4'h0;
                1, 2, 9: op = 4'h1;
                3, 4:    op = 4'h2;
                5, 6, 7: op = 4'h3;
                default: op = 4'($urandom_range(4, 15));
            endcase
            do_req(mk(op, 4'($urandom), 3'($urandom), $urandom), $urandom_range(0, 3), 1'b0);
        end

        // Back-to-back NOPs with rdy held: one pop every three cycles
        bus.in_msg     = mk(4'h0, 4'h1, 3'd0, 32'h0);
        bus.in_msg_rdy = 1'b1;
        last = -1;
        cnt  = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (bus.in_msg_ack) begin
                if (last >= 0) check("nop_spacing", 64'(c - last), 3);
                last = c;
                cnt++;
            end
        end
        bus.in_msg_rdy = 1'b0;
        check("nop_count", 64'(cnt), 10);
        repeat (3) begin @(posedge clk); #1; end

        // Reset while the WRITE is executing: the write must not land
        bus.in_msg     = mk(4'h1, 4'h4, 3'd5, 32'h55AA55AA);
        bus.in_msg_rdy = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.in_msg_ack && n < 20);
        check("exec_ack_latency", n, 1);
        bus.in_msg_rdy = 1'b0;
        @(posedge clk); #1;
        check("exec_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        reset_model();
        check("exec_rst_busy", busy, 0);
        check("exec_rst_rdy", bus.out_msg_rdy, 0);
        check("exec_rst_err", err_cnt, 0);
        do_req(mk(4'h2, 4'h0, 3'd5, 32'h0), 0, 1'b0);
        do_req(mk(4'h2, 4'h0, 3'd3, 32'h0), 0, 1'b0);

        // Reset while the reply is held in SEND
        do_req(mk(4'h1, 4'h6, 3'd2, 32'h0BADF00D), 1, 1'b1);
        do_req(mk(4'h2, 4'h6, 3'd2, 32'h0), 0, 1'b0);

        // Drive the error counter into saturation
        for (int i = 0; i < 300; i++) begin
            do_req(mk(4'($urandom_range(4, 15)), 4'($urandom), 3'($urandom), $urandom), 0, 1'b0);
        end
        check("err_saturated", err_cnt, 8'hFF);
        do_req(mk(4'h3, 4'h2, 3'd7, 32'hFFFFFFFF), 0, 1'b0);
        do_req(mk(4'h3, 4'h2, 3'd7, 32'h3), 0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
